fifo_read_streamer: RTL

FIFO_READ_STREAMER -- requirements
Module: fifo_read_streamer

---
 rtl/fifo_read_streamer.sv | 102 ++++++++++
 1 files changed

// File: rtl/fifo_read_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_read_streamer
//  Description : Turns the registered read port of a synchronous FIFO into a
//                valid/ready stream. A 3-entry skid buffer absorbs the one
//                cycle read latency, so the downstream side can stall without
//                any combinational path from i_ready to o_fifo_read.
//
//  Ports
//    clk              : single clock, rising edge
//    i_rst            : synchronous active-high reset
//    i_fifo_empty     : upstream FIFO empty flag
//    i_fifo_read_data : upstream FIFO registered read data
//    o_fifo_read      : pop request to the upstream FIFO
//    i_flush          : discard buffered and in-flight words
//    o_valid          : downstream word valid
//    o_data           : downstream word
//    i_ready          : downstream accepts the word
//    o_level          : words currently held in the buffer (0..3)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_streamer #(
   parameter int DataWidth = 32
) (
   input  logic                 clk,
   input  logic                 i_rst,
   input  logic                 i_fifo_empty,
   input  logic [DataWidth-1:0] i_fifo_read_data,
   output logic                 o_fifo_read,
   input  logic                 i_flush,
   output logic                 o_valid,
   output logic [DataWidth-1:0] o_data,
   input  logic                 i_ready,
   output logic [1:0]           o_level
);

   localparam logic [1:0] c_last_idx  = 2'd2;
   localparam logic [2:0] c_max_issue = 3'd2;

   logic [DataWidth-1:0] r_buf [0:2];
   logic [1:0]           r_head;
   logic [1:0]           r_tail;
   logic [1:0]           r_count;
   logic                 r_in_flight;

   logic [2:0]           w_occupancy;
   logic                 w_fifo_read;
   logic                 w_capture;
   logic                 w_pop;

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == c_last_idx) ? 2'd0 : p + 2'd1;
   endfunction

   // Buffered words plus the word still in the FIFO output register. A read
   // is only issued while a free slot is guaranteed for its data, so a capture
   // can never land in a full buffer even if the consumer stalls forever.
   assign w_occupancy = {1'b0, r_count} + {2'b00, r_in_flight};
   assign w_fifo_read = !i_fifo_empty && !i_flush && !i_rst && (w_occupancy <= c_max_issue);

   // The FIFO read data is valid in the cycle after the pop request.
   assign w_capture   = r_in_flight && !i_flush;
   assign w_pop       = (r_count != 2'd0) && i_ready && !i_flush;

   always_ff @(posedge clk) begin
      if (i_rst || i_flush) begin
         r_head      <= 2'd0;
         r_tail      <= 2'd0;
         r_count     <= 2'd0;
         r_in_flight <= 1'b0;
      end else begin
         r_in_flight <= w_fifo_read;
         if (w_capture) begin
            r_tail <= next_ptr(r_tail);
         end
         if (w_pop) begin
            r_head <= next_ptr(r_head);
         end
         case ({w_capture, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Data storage is deliberately left unreset; o_data is ignored while
   // o_valid is low.
   always_ff @(posedge clk) begin
      if (w_capture && !i_rst) begin
         r_buf[r_tail] <= i_fifo_read_data;
      end
   end

   assign o_fifo_read = w_fifo_read;
   assign o_valid     = (r_count != 2'd0);
   assign o_data      = r_buf[r_head];
   assign o_level     = r_count;

endmodule
`default_nettype wire
